// File: rtl/load_store_sequencer.sv
// Data-memory load/store sequencer: alignment check, req/ack bus cycle with strobes,
// timeout supervision and load-data formatting for the rv32i core.
module load_store_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  mem_read_type,
  input  logic [3:0]  mem_write_mask,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_BYTE = 3'd1;
  localparam logic [2:0] RD_HALF = 3'd2;
  localparam logic [2:0] RD_WORD = 3'd3;
  localparam logic [2:0] RD_BU   = 3'd4;
  localparam logic [2:0] RD_HU   = 3'd5;
  localparam logic [3:0] WR_NONE = 4'b0000;
  localparam logic [3:0] WR_BYTE = 4'b0001;
  localparam logic [3:0] WR_HALF = 4'b0011;
  localparam logic [3:0] WR_WORD = 4'b1111;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

  state_t             state, next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         rd_q, rd_d;
  logic [1:0]         off_q, off_d;
  logic               is_read, is_write, bad_access, timeout_hit;
  logic               busy_d, done_d, fault_d, bus_req_d, bus_we_d;
  logic [31:0]        load_data_d, bus_addr_d, bus_wdata_d, shifted;
  logic [3:0]         bus_wstrb_d;

  // Request decode: misalignment and illegal encodings both end in FAULT
  always_comb begin
    is_read    = (mem_read_type != RD_NONE);
    is_write   = (mem_write_mask != WR_NONE);
    bad_access = is_read && is_write;
    case (mem_read_type)
      RD_NONE, RD_BYTE, RD_BU: ;
      RD_HALF, RD_HU:          if (addr[0]) bad_access = 1'b1;
      RD_WORD:                 if (|addr[1:0]) bad_access = 1'b1;
      default:                 bad_access = 1'b1;
    endcase
    case (mem_write_mask)
      WR_NONE, WR_BYTE: ;
      WR_HALF:          if (addr[0]) bad_access = 1'b1;
      WR_WORD:          if (|addr[1:0]) bad_access = 1'b1;
      default:          bad_access = 1'b1;
    endcase
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start && (is_read || is_write)) next = bad_access ? FAULT : REQ;
      REQ:     if (bus_ack) next = RESP;
               else if (timeout_hit) next = FAULT;
      RESP:    next = IDLE;
      FAULT:   next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Output/datapath next values; everything lands in registers below
  always_comb begin
    busy_d      = (next == REQ);
    bus_req_d   = (next == REQ);
    done_d      = (next == RESP) || (next == FAULT);
    fault_d     = done_d ? (next == FAULT) : fault;
    load_data_d = load_data;
    cnt_d       = (state == REQ && next == REQ) ? cnt_q + CNT_W'(1) : '0;
    rd_d        = rd_q;
    off_d       = off_q;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wstrb_d = bus_wstrb;
    bus_wdata_d = bus_wdata;
    shifted     = bus_rdata >> {off_q, 3'b000};

    if (state == IDLE && next == REQ) begin
      rd_d        = mem_read_type;
      off_d       = addr[1:0];
      bus_we_d    = is_write;
      bus_addr_d  = {addr[31:2], 2'b00};
      bus_wstrb_d = is_write ? 4'(mem_write_mask << addr[1:0]) : 4'b0000;
      bus_wdata_d = store_data << {addr[1:0], 3'b000};
    end

    if (next == FAULT) load_data_d = '0;
    else if (next == RESP) begin
      case (rd_q)
        RD_BYTE: load_data_d = {{24{shifted[7]}}, shifted[7:0]};
        RD_BU:   load_data_d = {24'h0, shifted[7:0]};
        RD_HALF: load_data_d = {{16{shifted[15]}}, shifted[15:0]};
        RD_HU:   load_data_d = {16'h0, shifted[15:0]};
        RD_WORD: load_data_d = bus_rdata;
        default: load_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      load_data <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      cnt_q     <= '0;
      rd_q      <= RD_NONE;
      off_q     <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
      load_data <= load_data_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wstrb <= bus_wstrb_d;
      bus_wdata <= bus_wdata_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      off_q     <= off_d;
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed bench for load_store_sequencer; expected completions are queued at launch
// and popped when done pulses.
module tb_load_store_sequencer;

  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_BYTE = 3'd1;
  localparam logic [2:0] RD_HALF = 3'd2;
  localparam logic [2:0] RD_WORD = 3'd3;
  localparam logic [2:0] RD_BU   = 3'd4;
  localparam logic [2:0] RD_HU   = 3'd5;
  localparam logic [3:0] WR_NONE = 4'b0000;
  localparam logic [3:0] WR_BYTE = 4'b0001;
  localparam logic [3:0] WR_HALF = 4'b0011;
  localparam logic [3:0] WR_WORD = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mem_read_type;
  logic [3:0]  mem_write_mask;
  logic [31:0] addr, store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  typedef struct packed {
    logic        f;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  load_store_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_read_type(mem_read_type), .mem_write_mask(mem_write_mask),
    .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .fault(fault), .load_data(load_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [2:0] rd, input logic [3:0] wr,
                             input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    start = 1'b1; mem_read_type = rd; mem_write_mask = wr; addr = a; store_data = sd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    check($sformatf("%s.done", tag), 32'(done), 32'd1);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s.sb: observed=empty queue expected=pending entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check($sformatf("%s.fault", tag), 32'(fault), 32'(e.f));
      check($sformatf("%s.load_data", tag), load_data, e.d);
    end
  endtask

  task automatic bus_access(input string tag, input logic [2:0] rd, input logic [3:0] wr,
                            input logic [31:0] a, input logic [31:0] sd, input int delay,
                            input logic [31:0] rdata, input logic [31:0] exp_addr,
                            input logic exp_we, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
    sb.push_back('{f: 1'b0, d: exp_ld});
    drive_start(rd, wr, a, sd);
    check($sformatf("%s.bus_req", tag), 32'(bus_req), 32'd1);
    check($sformatf("%s.busy", tag), 32'(busy), 32'd1);
    check($sformatf("%s.bus_addr", tag), bus_addr, exp_addr);
    check($sformatf("%s.bus_we", tag), 32'(bus_we), 32'(exp_we));
    check($sformatf("%s.bus_wstrb", tag), 32'(bus_wstrb), 32'(exp_strb));
    if (exp_we) check($sformatf("%s.bus_wdata", tag), bus_wdata, exp_wdata);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check($sformatf("%s.req_hold", tag), 32'(bus_req), 32'd1);
    end
    bus_ack = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = '0;
    check_done(tag);
    check($sformatf("%s.busy_done", tag), 32'(busy), 32'd0);
  endtask

  task automatic fault_access(input string tag, input logic [2:0] rd, input logic [3:0] wr,
                              input logic [31:0] a);
    sb.push_back('{f: 1'b1, d: 32'h0});
    drive_start(rd, wr, a, 32'hFFFF_FFFF);
    check($sformatf("%s.bus_req", tag), 32'(bus_req), 32'd0);
    check_done(tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_read_type = RD_NONE; mem_write_mask = WR_NONE;
    addr = '0; store_data = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst.bus_req", 32'(bus_req), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.load_data", load_data, 32'd0);
    check("rst.bus_addr", bus_addr, 32'd0);
    rst_n = 1'b1;

    bus_access("lw", RD_WORD, WR_NONE, 32'h100, 32'h0, 0, 32'hDEADBEEF,
               32'h100, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    check("hold.done", 32'(done), 32'd0);
    check("hold.load_data", load_data, 32'hDEADBEEF);

    bus_access("lb", RD_BYTE, WR_NONE, 32'h103, 32'h0, 1, 32'h80112233,
               32'h100, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF80);
    bus_access("lbu", RD_BU, WR_NONE, 32'h103, 32'h0, 0, 32'h80112233,
               32'h100, 1'b0, 4'b0000, 32'h0, 32'h00000080);
    bus_access("lh", RD_HALF, WR_NONE, 32'h102, 32'h0, 2, 32'h80112233,
               32'h100, 1'b0, 4'b0000, 32'h0, 32'hFFFF8011);
    bus_access("lhu", RD_HU, WR_NONE, 32'h102, 32'h0, 0, 32'h80112233,
               32'h100, 1'b0, 4'b0000, 32'h0, 32'h00008011);
    bus_access("lb1", RD_BYTE, WR_NONE, 32'h101, 32'h0, 3, 32'h80112233,
               32'h100, 1'b0, 4'b0000, 32'h0, 32'h00000022);
    bus_access("sh", RD_NONE, WR_HALF, 32'h202, 32'h1234ABCD, 2, 32'h0,
               32'h200, 1'b1, 4'b1100, 32'hABCD0000, 32'h0);
    bus_access("sb", RD_NONE, WR_BYTE, 32'h001, 32'h123456EE, 0, 32'h0,
               32'h000, 1'b1, 4'b0010, 32'h3456EE00, 32'h0);

    fault_access("sw_mis", RD_NONE, WR_WORD, 32'h301);
    fault_access("lh_mis", RD_HALF, WR_NONE, 32'h5);
    fault_access("rd_wr", RD_WORD, WR_WORD, 32'h0);

    // Timeout: bus_req held four cycles, then a faulting done
    sb.push_back('{f: 1'b1, d: 32'h0});
    drive_start(RD_WORD, WR_NONE, 32'h40, 32'h0);
    check("to.req1", 32'(bus_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("to.req_hold", 32'(bus_req), 32'd1);
    end
    @(negedge clk);
    check_done("to");
    check("to.req_drop", 32'(bus_req), 32'd0);

    // NONE/NONE start is ignored
    drive_start(RD_NONE, WR_NONE, 32'h80, 32'h0);
    check("ign.busy", 32'(busy), 32'd0);
    check("ign.done", 32'(done), 32'd0);
    @(negedge clk);
    check("ign.done2", 32'(done), 32'd0);

    // start while busy and in the done cycle are ignored
    sb.push_back('{f: 1'b0, d: 32'h11223344});
    drive_start(RD_WORD, WR_NONE, 32'h400, 32'h0);
    start = 1'b1; mem_read_type = RD_NONE; mem_write_mask = WR_WORD; addr = 32'h800;
    @(negedge clk);
    start = 1'b0;
    check("bsy.bus_addr", bus_addr, 32'h400);
    check("bsy.bus_we", 32'(bus_we), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = '0;
    check_done("bsy");
    start = 1'b1; mem_read_type = RD_NONE; mem_write_mask = WR_WORD; addr = 32'h900;
    @(negedge clk);
    start = 1'b0;
    check("resp_start.bus_req", 32'(bus_req), 32'd0);
    check("resp_start.done", 32'(done), 32'd0);

    // Async reset abandons an in-flight request
    drive_start(RD_WORD, WR_NONE, 32'h600, 32'h0);
    check("ar.req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar.bus_req", 32'(bus_req), 32'd0);
    check("ar.busy", 32'(busy), 32'd0);
    check("ar.done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_access("post_rst", RD_WORD, WR_NONE, 32'h700, 32'h0, 1, 32'hCAFEF00D,
               32'h700, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D);

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
